// File: rtl/inst_fetch_queue_if.sv
// Fetch-side bus bundle: instruction-memory request/grant/response plus the
// valid/ready instruction stream toward the core.
interface inst_fetch_queue_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  // Fetch queue side: issues memory requests and sources instructions.
  modport master (
    output mem_req, mem_addr, inst_valid, inst_data, inst_pc,
    input  mem_gnt, mem_rvalid, mem_rdata, inst_ready
  );

  // Memory/core side.
  modport slave (
    input  mem_req, mem_addr, inst_valid, inst_data, inst_pc,
    output mem_gnt, mem_rvalid, mem_rdata, inst_ready
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Sequential instruction fetcher with a DEPTH-entry {pc, word} FIFO and redirect flush.
// Define IFQ_BYPASS_EN to forward a response straight to the core when the FIFO is empty.
module inst_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4,
  parameter int          CNT_W    = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  inst_fetch_queue_if.master   bus,
  input  logic                 redirect,
  input  logic [31:0]          redirect_pc,
  output logic [CNT_W-1:0]     occupancy
);

  localparam int               PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,  // no request outstanding
    WAIT,  // one request outstanding, response will be kept
    DROP   // one request outstanding, response belongs to a flushed stream
  } state_t;

  state_t             state, state_nxt;
  logic [31:0]        fetch_pc;
  logic [31:0]        req_pc;
  logic [31:0]        data_q [DEPTH];
  logic [31:0]        pc_q   [DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   count;
  logic               grant, rsp, push, pop, fifo_valid;

  assign fifo_valid = (count != '0);
  assign occupancy  = count;

  // Only IDLE may request, so the in-flight term of the credit check is always zero here.
  // Gating with reset keeps the bus quiet while the block is held in reset.
  assign bus.mem_req  = reset & (state == IDLE) & (count < FULL) & ~redirect;
  assign bus.mem_addr = fetch_pc;
  assign grant        = bus.mem_req & bus.mem_gnt;
  assign rsp          = (state == WAIT) & bus.mem_rvalid & ~redirect;
  assign pop          = fifo_valid & bus.inst_ready;

`ifdef IFQ_BYPASS_EN
  logic bypass;
  assign bypass         = ~fifo_valid & rsp;
  assign bus.inst_valid = fifo_valid | bypass;
  assign bus.inst_data  = fifo_valid ? data_q[rd_ptr] : (bypass ? bus.mem_rdata : '0);
  assign bus.inst_pc    = fifo_valid ? pc_q[rd_ptr]   : (bypass ? req_pc        : '0);
  // A bypassed word the core takes immediately never enters the FIFO.
  assign push           = rsp & ~(bypass & bus.inst_ready);
`else
  assign bus.inst_valid = fifo_valid;
  assign bus.inst_data  = fifo_valid ? data_q[rd_ptr] : '0;
  assign bus.inst_pc    = fifo_valid ? pc_q[rd_ptr]   : '0;
  assign push           = rsp;
`endif

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    unique case (state)
      IDLE:    if (grant) state_nxt = WAIT;
      WAIT:    if (bus.mem_rvalid) state_nxt = IDLE;
               else if (redirect) state_nxt = DROP;
      DROP:    if (bus.mem_rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      state <= state_nxt;
      if (redirect)   fetch_pc <= redirect_pc & ~32'h3;
      else if (grant) fetch_pc <= fetch_pc + 32'd4;
      if (grant) req_pc <= fetch_pc;

      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop)      count <= count + CNT_W'(1);
        else if (pop && !push) count <= count - CNT_W'(1);
      end
    end
  end

  // NOTE: storage is not reset; the head is gated by occupancy, so stale entries never reach the core.
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr] <= bus.mem_rdata;
      pc_q[wr_ptr]   <= req_pc;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: directed phases push expected {pc, data}
// pairs, a monitor compares every consumed instruction against them.
module tb_inst_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [2:0]  occupancy;

  always #5 clk = ~clk;

  inst_fetch_queue_if bus ();

  inst_fetch_queue #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (4),
    .CNT_W    (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .occupancy   (occupancy)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  int          n_checks = 0;
  int          n_pass   = 0;
  exp_t        sb_q [$];
  exp_t        mon_e;
  logic [31:0] gnt_q [$];
  int          rsp_timer = 0;
  int          rsp_delay = 1;
  logic [31:0] mem_word  = 32'h0000_0013;
  logic [31:0] rsp_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] gnt_at(input int i);
    if (i < gnt_q.size()) return gnt_q[i];
    return 32'hFFFF_FFFF;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sb_push(input logic [31:0] pc, input logic [31:0] data);
    sb_q.push_back('{pc: pc, data: data});
  endtask

  // Memory model: one response rsp_delay cycles after each grant, data latched at grant.
  always @(negedge clk) begin
    bus.mem_rvalid = 1'b0;
    if (rsp_timer > 0) begin
      rsp_timer--;
      if (rsp_timer == 0) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rsp_data;
      end
    end
    #1;
    if (bus.mem_req === 1'b1 && bus.mem_gnt === 1'b1) begin
      gnt_q.push_back(bus.mem_addr);
      rsp_timer = rsp_delay;
      rsp_data  = mem_word;
    end
  end

  // Monitor: every consumed instruction must match the scoreboard head.
  always @(negedge clk) begin
    #2;
    if (reset === 1'b1 && bus.inst_valid === 1'b1 && bus.inst_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_pop: got pc 0x%08h data 0x%08h, want no instruction",
                 bus.inst_pc, bus.inst_data);
      end else begin
        mon_e = sb_q.pop_front();
        check("pop_pc", bus.inst_pc, mon_e.pc);
        check("pop_data", bus.inst_data, mon_e.data);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset          = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = '0;
    bus.mem_gnt    = 1'b0;
    bus.inst_ready = 1'b0;
    rsp_delay      = 1;
    mem_word       = 32'h0000_0013;
    #3;
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_inst_valid", bus.inst_valid, 0);
    check("rst_inst_data", bus.inst_data, 32'h0);
    check("rst_inst_pc", bus.inst_pc, 32'h0);
    check("rst_occupancy", occupancy, 0);
    cyc(2);
    reset = 1'b1;
    gnt_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

  initial begin
    reset          = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = '0;
    bus.mem_gnt    = 1'b0;
    bus.inst_ready = 1'b0;

    // Streaming with zero-wait memory and an always-ready core.
    do_reset();
    for (int i = 0; i < 4; i++) sb_push(32'(i * 4), 32'h0000_0013);
    bus.mem_gnt    = 1'b1;
    bus.inst_ready = 1'b1;
    cyc(7);
    bus.mem_gnt = 1'b0;
    cyc(3); #3;
    check("p1_grants", gnt_q.size(), 4);
    for (int i = 0; i < 4; i++) check("p1_gnt_addr", gnt_at(i), 32'(i * 4));
    check("p1_mem_req", bus.mem_req, 1);
    check("p1_mem_addr", bus.mem_addr, 32'h10);
    check("p1_occupancy", occupancy, 0);
    check("p1_sb_drained", sb_q.size(), 0);

    // Stalled core: FIFO fills to DEPTH, then drains in order.
    do_reset();
    bus.mem_gnt = 1'b1;
    cyc(10); #3;
    check("p2_full_occ", occupancy, 4);
    check("p2_hold_pc", bus.inst_pc, 32'h0);
    check("p2_hold_data", bus.inst_data, 32'h0000_0013);
    cyc(2);
    bus.mem_gnt    = 1'b0;
    bus.inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) sb_push(32'(i * 4), 32'h0000_0013);
    #3;
    check("p2_grants", gnt_q.size(), 4);
    check("p2_no_credit_on_pop", bus.mem_req, 0);
    check("p2_still_full", occupancy, 4);
    check("p2_inst_pc", bus.inst_pc, 32'h0);
    cyc(1); #3;
    check("p2_resume_req", bus.mem_req, 1);
    check("p2_resume_addr", bus.mem_addr, 32'h10);
    cyc(3); #3;
    check("p2_empty_occ", occupancy, 0);
    check("p2_empty_valid", bus.inst_valid, 0);
    check("p2_sb_drained", sb_q.size(), 0);

    // Redirect while a slow response is outstanding; flushed entries and late data vanish.
    do_reset();
    bus.mem_gnt = 1'b1;
    cyc(3);
    rsp_delay = 4;
    mem_word  = 32'hBAD0_0008;
    cyc(2);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    rsp_delay   = 1;
    mem_word    = 32'h0000_0013;
    sb_push(32'h100, 32'h0000_0013);
    #3;
    check("p3_pre_flush_occ", occupancy, 2);
    check("p3_redirect_req", bus.mem_req, 0);
    cyc(1);
    redirect       = 1'b0;
    bus.inst_ready = 1'b1;
    #3;
    check("p3_flush_occ", occupancy, 0);
    check("p3_flush_valid", bus.inst_valid, 0);
    check("p3_drop_req", bus.mem_req, 0);
    cyc(2); #3;
    check("p3_late_rsp_valid", bus.inst_valid, 0);
    check("p3_late_rsp_req", bus.mem_req, 0);
    cyc(1); #3;
    check("p3_new_req", bus.mem_req, 1);
    check("p3_new_addr", bus.mem_addr, 32'h100);
    cyc(1);
    bus.mem_gnt = 1'b0;
    cyc(3); #3;
    check("p3_grants", gnt_q.size(), 4);
    check("p3_gnt_addr", gnt_at(3), 32'h100);
    check("p3_sb_drained", sb_q.size(), 0);

    // Ungranted request held stable, then withdrawn by a redirect.
    do_reset();
    bus.inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #3;
      check("p4_hold_req", bus.mem_req, 1);
      check("p4_hold_addr", bus.mem_addr, 32'h0);
      cyc(1);
    end
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    sb_push(32'h200, 32'h0000_0013);
    #3;
    check("p4_withdraw_req", bus.mem_req, 0);
    cyc(1);
    redirect = 1'b0;
    #3;
    check("p4_reissue_req", bus.mem_req, 1);
    check("p4_reissue_addr", bus.mem_addr, 32'h200);
    cyc(1);
    bus.mem_gnt = 1'b1;
    cyc(1);
    bus.mem_gnt = 1'b0;
    cyc(3); #3;
    check("p4_grants", gnt_q.size(), 1);
    check("p4_gnt_addr", gnt_at(0), 32'h200);
    check("p4_sb_drained", sb_q.size(), 0);

    // Asynchronous reset mid-stream; a response for the old stream arrives afterwards.
    do_reset();
    bus.mem_gnt = 1'b1;
    cyc(6);
    rsp_delay = 2;
    mem_word  = 32'hBAD0_000C;
    #3;
    check("p5_occ3", occupancy, 3);
    cyc(1);
    bus.mem_gnt = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    check("p5_async_mem_req", bus.mem_req, 0);
    check("p5_async_mem_addr", bus.mem_addr, 32'h0);
    check("p5_async_valid", bus.inst_valid, 0);
    check("p5_async_data", bus.inst_data, 32'h0);
    check("p5_async_pc", bus.inst_pc, 32'h0);
    check("p5_async_occ", occupancy, 0);
    cyc(1);
    reset          = 1'b1;
    bus.mem_gnt    = 1'b1;
    bus.inst_ready = 1'b1;
    rsp_delay      = 1;
    mem_word       = 32'h0000_0055;
    gnt_q.delete();
    sb_push(32'h0, 32'h0000_0055);
    #3;
    check("p5_restart_req", bus.mem_req, 1);
    check("p5_restart_addr", bus.mem_addr, 32'h0);
    cyc(1);
    bus.mem_gnt = 1'b0;
    cyc(3); #3;
    check("p5_grants", gnt_q.size(), 1);
    check("p5_sb_drained", sb_q.size(), 0);

    // Response latency into an empty FIFO.
    do_reset();
    bus.mem_gnt    = 1'b1;
    bus.inst_ready = 1'b1;
    mem_word       = 32'hDEAD_BEEF;
    sb_push(32'h0, 32'hDEAD_BEEF);
    cyc(1);
    bus.mem_gnt = 1'b0;
    #3;
`ifdef IFQ_BYPASS_EN
    check("p6_bypass_valid", bus.inst_valid, 1);
    check("p6_bypass_data", bus.inst_data, 32'hDEAD_BEEF);
    check("p6_bypass_pc", bus.inst_pc, 32'h0);
    check("p6_bypass_occ", occupancy, 0);
    cyc(1); #3;
    check("p6_not_pushed_occ", occupancy, 0);
    check("p6_not_pushed_valid", bus.inst_valid, 0);
`else
    check("p6_rsp_cycle_valid", bus.inst_valid, 0);
    check("p6_rsp_cycle_occ", occupancy, 0);
    cyc(1); #3;
    check("p6_next_valid", bus.inst_valid, 1);
    check("p6_next_data", bus.inst_data, 32'hDEAD_BEEF);
    check("p6_next_occ", occupancy, 1);
`endif
    cyc(2); #3;
    check("p6_sb_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Instruction fetch front-end that sits directly upstream of the Riscv core and feeds its Instruction input.
- Generates sequential word fetch requests to instruction memory over a request/grant/response handshake.
- Buffers returned words, each tagged with its PC, in a DEPTH-entry FIFO.
- Delivers them to the core over valid/ready, and flushes/redirects on taken branches or jumps.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.
- DEPTH, 4, FIFO entries; power of 2, range 2..16.
- CNT_W, 3, occupancy width; must equal clog2(DEPTH)+1.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset; asserted when 0.
- mem_req  out  1  fetch request valid.
- mem_addr  out  32  word-aligned fetch address; held stable while mem_req=1 and mem_gnt=0.
- mem_gnt  in  1  memory accepts request this cycle (handshake = mem_req & mem_gnt).
- mem_rvalid  in  1  response valid; exactly one response per granted request, earliest the cycle after grant.
- mem_rdata  in  32  response instruction word.
- inst_valid  out  1  head entry valid toward core.
- inst_ready  in  1  core consumes head this cycle (pop = inst_valid & inst_ready).
- inst_data  out  32  head instruction word.
- inst_pc  out  32  PC of head instruction.
- redirect  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored (forced 0).
- occupancy  out  CNT_W  valid FIFO entries.

Behaviour:
- Reset (reset=0, async):
  - mem_req=0, mem_addr=RESET_PC, fetch_pc=RESET_PC.
  - FIFO empty; inst_valid=0, inst_data=0, inst_pc=0, occupancy=0; FSM=IDLE.
- FSM states:
  - IDLE: no outstanding request. mem_req=1 iff occupancy + 0 < DEPTH (credit available) and redirect=0. On grant: record req_pc=fetch_pc, fetch_pc += 4 (mod 2^32), go WAIT.
  - WAIT: one request outstanding; mem_req=0. On mem_rvalid: push {req_pc, mem_rdata}, go IDLE. Only one outstanding request ever.
  - DROP: outstanding response belongs to a flushed stream; mem_req=0. On mem_rvalid: discard, go IDLE.
- Credit: a request is issued only if occupancy + (state==WAIT) < DEPTH, so a push can never overflow. A pop in the same cycle does not grant extra credit that cycle.
- First request is asserted in the first clock cycle after reset deasserts.
- Push/pop same cycle: both occur; occupancy unchanged.
- Pop with FIFO empty: impossible, since inst_valid=0.
- FIFO pointers wrap modulo DEPTH.
- Latency: rvalid at cycle N gives inst_valid=1 at cycle N+1 (FIFO previously empty). Zero-wait memory (gnt in the request cycle, rvalid the next cycle) sustains 1 instruction per 2 cycles.
- Redirect (highest priority):
  - In the redirect cycle: FIFO cleared (occupancy=0, inst_valid=0 next cycle), fetch_pc <= {redirect_pc[31:2],2'b00}, mem_req forced 0 (an ungranted pending request is withdrawn).
  - If state==WAIT, or a grant occurs in the same cycle, go DROP unless mem_rvalid also arrives in that cycle. A response arriving in the redirect cycle is discarded.
  - Any pop in the redirect cycle still counts as consumed by the core.
  - The first new request is issued the cycle after redirect (or after the DROP completes).
- Back-to-back redirects: the last one wins; DROP persists until the single outstanding response returns.
- Reset mid-operation: all state returns to reset values immediately. A memory response arriving after reset release with no outstanding request is ignored.
- inst_data and inst_pc hold their values while inst_valid=1 and inst_ready=0.

Optional Feature:
- Macro: IFQ_BYPASS_EN.
- Defined: when the FIFO is empty, state==WAIT, mem_rvalid=1 and redirect=0, the response drives inst_valid/inst_data/inst_pc combinationally in the same cycle.
  - If inst_ready=1 that cycle, the word is consumed and not pushed; otherwise it is pushed as normal.
  - Zero-wait throughput becomes 1 instruction per 2 cycles at latency 0.
- Not defined: responses always pass through the FIFO (1-cycle latency), and outputs are purely registered/FIFO-head driven.

Test Plan:
- Reset release, mem_gnt=1, 1-cycle rvalid returning 0x00000013, inst_ready=1 → mem_addr sequence 0x0,0x4,0x8…; inst_pc sequence 0x0,0x4,0x8…, each with inst_data=0x00000013.
- inst_ready=0 with DEPTH=4 → exactly 4 grants; occupancy reaches 4 and mem_req stays 0. Raising inst_ready pops PCs 0x0..0xC in order, and requests resume at 0x10.
- Redirect to 0x00000103 while in WAIT → FIFO flushed, late response discarded (never appears on inst_*), next mem_addr=0x100, next inst_pc=0x100.
- mem_gnt held 0 for 5 cycles → mem_addr stable and mem_req=1 throughout. Redirect to 0x200 in cycle 3 → mem_req drops that cycle, then re-asserts with mem_addr=0x200.
- reset pulsed low for 1 cycle with occupancy=3 mid-stream → all outputs return to reset values asynchronously; fetch restarts at RESET_PC.
- IFQ_BYPASS_EN defined, FIFO empty, rvalid with 0xDEADBEEF and inst_ready=1 → inst_valid=1 with inst_data=0xDEADBEEF in the same cycle; occupancy stays 0.
